md_issue_unit: RTL and testbench



---
 rtl/md_pkg.sv | 32 +++
 rtl/md_iter_datapath.sv | 87 ++++++++
 rtl/md_issue_unit.sv | 169 ++++++++++++++++
 tb/tb_md_issue_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the iterative multiply/divide unit: operand width,
// iteration count, ALU opcodes, FSM state encoding, writeback rstatus codes and
// a two's-complement magnitude helper.
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Writeback pairs these with o_exception to report the faulting op type.
    localparam logic [3:0] RSTATUS_MUL = 4'd4;
    localparam logic [3:0] RSTATUS_DIV = 4'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Magnitude of a two's-complement value, read as unsigned. INT_MIN maps to
    // 0x80000000, which is its correct unsigned magnitude.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
        return x[MD_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// -----------------------------------------------------------------------------
// md_iter_datapath
// Unsigned magnitude datapath for the multiply/divide unit. Holds the 64-bit
// shift-add accumulator, the quotient and remainder registers and the operand
// they iterate against, and performs one step per enabled cycle.
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   load_i            capture operand magnitudes (start of an op)
//   step_i            perform one iteration
//   is_mul_i          op type: 1 = multiply, 0 = divide
//   mag_a_i, mag_b_i  operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   prod_nxt_o        accumulator value after the current step (multiply)
//   quo_nxt_o         quotient value after the current step (divide)
// -----------------------------------------------------------------------------
module md_iter_datapath
    import md_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic                    is_mul_i,
    input  logic [MD_WIDTH-1:0]     mag_a_i,
    input  logic [MD_WIDTH-1:0]     mag_b_i,
    output logic [2*MD_WIDTH-1:0]   prod_nxt_o,
    output logic [MD_WIDTH-1:0]     quo_nxt_o
);

    logic [2*MD_WIDTH-1:0] acc_q, acc_d;
    logic [MD_WIDTH-1:0]   quo_q, quo_d;
    logic [MD_WIDTH-1:0]   rem_q, rem_d;
    logic [MD_WIDTH-1:0]   opnd_q, opnd_d;

    logic [MD_WIDTH:0]     add_sum;
    logic [MD_WIDTH:0]     trial;
    logic [MD_WIDTH:0]     diff;
    logic [MD_WIDTH-1:0]   rem_nxt;

    always_comb begin
        // Multiply: the multiplier sits in the low half and shifts out LSB-first
        // while partial sums enter the high half with their carry.
        add_sum    = {1'b0, acc_q[2*MD_WIDTH-1:MD_WIDTH]}
                   + {1'b0, (acc_q[0] ? opnd_q : '0)};
        prod_nxt_o = {add_sum, acc_q[MD_WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder and
        // keep the subtraction only when it does not borrow.
        trial     = {rem_q, quo_q[MD_WIDTH-1]};
        diff      = trial - {1'b0, opnd_q};
        quo_nxt_o = {quo_q[MD_WIDTH-2:0], ~diff[MD_WIDTH]};
        rem_nxt   = diff[MD_WIDTH] ? trial[MD_WIDTH-1:0] : diff[MD_WIDTH-1:0];

        acc_d  = acc_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        opnd_d = opnd_q;

        if (load_i) begin
            opnd_d = is_mul_i ? mag_a_i : mag_b_i;
            acc_d  = {{MD_WIDTH{1'b0}}, mag_b_i};
            quo_d  = mag_a_i;
            rem_d  = '0;
        end else if (step_i) begin
            if (is_mul_i) begin
                acc_d = prod_nxt_o;
            end else begin
                quo_d = quo_nxt_o;
                rem_d = rem_nxt;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/md_issue_unit.sv
// -----------------------------------------------------------------------------
// md_issue_unit
// Iterative signed multiply/divide unit feeding the P/W latch. Accepts a MUL or
// DIV start pulse in IDLE or DONE, iterates for a fixed 32 cycles on operand
// magnitudes, then applies the sign fix-up and exception checks and presents
// the result with a one-cycle o_MD_rdy. o_busy stalls the front of the pipe.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   i_insn              instruction word captured at start
//   i_op_a, i_op_b      signed operands (multiplicand/dividend, multiplier/divisor)
//   i_mult, i_div       start pulses; multiply wins if both are high
//   o_insn, o_result    completed instruction and 32-bit result (held)
//   o_MD_rdy            one-cycle completion strobe
//   o_exception         mul overflow, divide by zero or INT_MIN/-1 (held)
//   o_busy              high while an op is iterating
// -----------------------------------------------------------------------------
module md_issue_unit
    import md_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [MD_WIDTH-1:0] i_insn,
    input  logic [MD_WIDTH-1:0] i_op_a,
    input  logic [MD_WIDTH-1:0] i_op_b,
    input  logic                i_mult,
    input  logic                i_div,
    output logic [MD_WIDTH-1:0] o_insn,
    output logic [MD_WIDTH-1:0] o_result,
    output logic                o_MD_rdy,
    output logic                o_exception,
    output logic                o_busy
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  rdy_q, rdy_d;
    logic                  exc_q, exc_d;
    logic [MD_WIDTH-1:0]   insn_q, insn_d;
    logic [MD_WIDTH-1:0]   result_q, result_d;
    logic [MD_WIDTH-1:0]   insn_cap_q, insn_cap_d;
    logic                  is_mul_q, is_mul_d;
    logic                  neg_q, neg_d;
    logic                  divz_q, divz_d;
    logic                  divovf_q, divovf_d;

    logic                  start;
    logic                  last;
    logic                  dp_is_mul;
    logic [2*MD_WIDTH-1:0] prod_mag;
    logic [MD_WIDTH-1:0]   quo_mag;
    logic [2*MD_WIDTH-1:0] prod_s;

    md_iter_datapath u_dp (
        .clock      (clock),
        .reset      (reset),
        .load_i     (start),
        .step_i     (state_q == MD_RUN),
        .is_mul_i   (dp_is_mul),
        .mag_a_i    (md_abs(i_op_a)),
        .mag_b_i    (md_abs(i_op_b)),
        .prod_nxt_o (prod_mag),
        .quo_nxt_o  (quo_mag)
    );

    always_comb begin
        start     = (i_mult | i_div) && (state_q != MD_RUN);
        last      = (state_q == MD_RUN) && (count_q == MD_CNT_W'(MD_ITERS - 1));
        dp_is_mul = start ? i_mult : is_mul_q;
        prod_s    = neg_q ? -prod_mag : prod_mag;

        state_d    = state_q;
        count_d    = count_q;
        busy_d     = busy_q;
        rdy_d      = 1'b0;
        exc_d      = exc_q;
        insn_d     = insn_q;
        result_d   = result_q;
        insn_cap_d = insn_cap_q;
        is_mul_d   = is_mul_q;
        neg_d      = neg_q;
        divz_d     = divz_q;
        divovf_d   = divovf_q;

        unique case (state_q)
            MD_IDLE: begin
                if (start) state_d = MD_RUN;
            end
            MD_RUN: begin
                count_d = count_q + 1'b1;
                if (last) begin
                    state_d = MD_DONE;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    insn_d  = insn_cap_q;
                    if (is_mul_q) begin
                        result_d = prod_s[MD_WIDTH-1:0];
                        // The signed product fits 32 bits only if bits [63:31]
                        // are a pure sign extension.
                        exc_d    = ~((&prod_s[2*MD_WIDTH-1:MD_WIDTH-1]) |
                                     ~(|prod_s[2*MD_WIDTH-1:MD_WIDTH-1]));
                    end else if (divz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (divovf_q) begin
                        result_d = {1'b1, {(MD_WIDTH-1){1'b0}}};
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo_mag : quo_mag;
                        exc_d    = 1'b0;
                    end
                end
            end
            MD_DONE: begin
                state_d = start ? MD_RUN : MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        // Output registers are left alone on start so a completion strobe in
        // DONE still carries the previous op's values.
        if (start) begin
            count_d    = '0;
            busy_d     = 1'b1;
            insn_cap_d = i_insn;
            is_mul_d   = i_mult;
            neg_d      = i_op_a[MD_WIDTH-1] ^ i_op_b[MD_WIDTH-1];
            divz_d     = (i_op_b == '0);
            divovf_d   = (i_op_a == {1'b1, {(MD_WIDTH-1){1'b0}}}) && (&i_op_b);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            exc_q      <= 1'b0;
            insn_q     <= '0;
            result_q   <= '0;
            insn_cap_q <= '0;
            is_mul_q   <= 1'b0;
            neg_q      <= 1'b0;
            divz_q     <= 1'b0;
            divovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
            exc_q      <= exc_d;
            insn_q     <= insn_d;
            result_q   <= result_d;
            insn_cap_q <= insn_cap_d;
            is_mul_q   <= is_mul_d;
            neg_q      <= neg_d;
            divz_q     <= divz_d;
            divovf_q   <= divovf_d;
        end
    end

    assign o_insn      = insn_q;
    assign o_result    = result_q;
    assign o_MD_rdy    = rdy_q;
    assign o_exception = exc_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_md_issue_unit.sv
module tb_md_issue_unit;

    logic        clock;
    logic        reset;
    logic [31:0] i_insn, i_op_a, i_op_b;
    logic        i_mult, i_div;
    logic [31:0] o_insn, o_result;
    logic        o_MD_rdy, o_exception, o_busy;

    int errors = 0;
    int checks = 0;

    md_issue_unit dut (
        .clock       (clock),
        .reset       (reset),
        .i_insn      (i_insn),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_mult      (i_mult),
        .i_div       (i_div),
        .o_insn      (o_insn),
        .o_result    (o_result),
        .o_MD_rdy    (o_MD_rdy),
        .o_exception (o_exception),
        .o_busy      (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, straight from the op rules.
    function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e);
        longint sa, sb, p, q;
        longint maxi, mini;
        maxi = 2147483647;
        mini = -maxi - 1;
        sa = $signed(a);
        sb = $signed(b);
        if (mul) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > maxi) || (p < mini);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (sa == mini && sb == -1) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = sa / sb;
            r = q[31:0];
            e = 1'b0;
        end
    endfunction

    // Pulse a start for one cycle; returns 1 time unit after the accepting edge.
    task automatic drive_start(input bit mul, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] insn);
        @(negedge clock);
        i_insn = insn;
        i_op_a = a;
        i_op_b = b;
        i_mult = mul;
        i_div  = !mul;
        @(posedge clock);
        #1;
        i_mult = 1'b0;
        i_div  = 1'b0;
    endtask

    // Follow an op from 1 unit after its accepting edge through completion and
    // the cycle after. inject_at > 0 pulses a second start before that edge.
    task automatic expect_completion(input string tag, input logic [31:0] exp_r,
                                     input bit exp_e, input logic [31:0] exp_insn,
                                     input int inject_at);
        bit window_ok;
        window_ok = 1'b1;
        if (!(o_busy === 1'b1 && o_MD_rdy === 1'b0)) window_ok = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            if (i == inject_at) begin
                @(negedge clock);
                i_insn = 32'hDEAD_BEEF;
                i_op_a = 32'd100;
                i_op_b = 32'd3;
                i_div  = 1'b1;
            end
            @(posedge clock);
            #1;
            i_div = 1'b0;
            if (!(o_busy === 1'b1 && o_MD_rdy === 1'b0)) window_ok = 1'b0;
        end
        check({tag, "_busy_window"}, {63'd0, window_ok}, 64'd1);
        @(posedge clock);
        #1;
        check({tag, "_busy_rdy"}, {62'd0, o_busy, o_MD_rdy}, 64'd1);
        check({tag, "_result"}, {32'd0, o_result}, {32'd0, exp_r});
        check({tag, "_exc"}, {63'd0, o_exception}, {63'd0, exp_e});
        check({tag, "_insn"}, {32'd0, o_insn}, {32'd0, exp_insn});
    endtask

    task automatic after_done(input string tag, input logic [31:0] exp_r);
        @(posedge clock);
        #1;
        check({tag, "_rdy_fall"}, {62'd0, o_busy, o_MD_rdy}, 64'd0);
        check({tag, "_hold"}, {32'd0, o_result}, {32'd0, exp_r});
    endtask

    task automatic run_op(input string tag, input bit mul, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input bit exp_e);
        logic [31:0] insn;
        insn = {mul ? 5'b00110 : 5'b00111, 27'($urandom)};
        drive_start(mul, a, b, insn);
        expect_completion(tag, exp_r, exp_e, insn, 0);
        after_done(tag, exp_r);
    endtask

    initial begin
        logic [31:0] ra, rb, mr, r1;
        bit          me, mul, no_rdy;

        reset  = 1'b1;
        i_insn = '0;
        i_op_a = '0;
        i_op_b = '0;
        i_mult = 1'b0;
        i_div  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", {o_insn, o_result}, 64'd0);
        check("reset_flags", {61'd0, o_MD_rdy, o_exception, o_busy}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases with hand-derived results.
        run_op("mul_6x7",      1'b1, 32'd6,          32'd7,          32'h0000_002A, 1'b0);
        run_op("div_m7_2",     1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2",     1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 1'b0);
        run_op("div_m8_m2",    1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'h0000_0004, 1'b0);
        run_op("div_by_zero",  1'b0, 32'd10,         32'd0,          32'h0000_0000, 1'b1);
        run_op("div_intmin",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
        run_op("mul_ovf",      1'b1, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);
        run_op("mul_m1_m1",    1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0);
        run_op("mul_intmin_1", 1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0);
        run_op("mul_intmin_m1",1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);

        // Reset at count 10 of a MUL: outputs clear without a clock edge.
        run_op("mul_pre_rst",  1'b1, 32'd9, 32'd9, 32'd81, 1'b0);
        drive_start(1'b1, 32'd6, 32'd7, 32'h1234_5678);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_data", {o_insn, o_result}, 64'd0);
        check("async_rst_flags", {61'd0, o_MD_rdy, o_exception, o_busy}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        no_rdy = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(posedge clock);
            #1;
            if (o_MD_rdy !== 1'b0 || o_busy !== 1'b0) no_rdy = 1'b0;
        end
        check("aborted_no_rdy", {63'd0, no_rdy}, 64'd1);
        run_op("div_100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 1'b0);

        // A start pulse while running is ignored.
        drive_start(1'b1, 32'd3, 32'd5, 32'hAAAA_0001);
        expect_completion("ignore_run", 32'd15, 1'b0, 32'hAAAA_0001, 5);
        after_done("ignore_run", 32'd15);

        // Start in the DONE cycle: strobe for op1, op2 completes 33 cycles later.
        drive_start(1'b1, 32'd11, 32'd13, 32'hBBBB_0001);
        expect_completion("b2b_op1", 32'd143, 1'b0, 32'hBBBB_0001, 0);
        drive_start(1'b0, 32'hFFFF_FF9C, 32'd9, 32'hBBBB_0002);
        check("b2b_restart_flags", {62'd0, o_busy, o_MD_rdy}, 64'd2);
        check("b2b_restart_hold", {o_insn, o_result}, {32'hBBBB_0001, 32'd143});
        expect_completion("b2b_op2", 32'hFFFF_FFF5, 1'b0, 32'hBBBB_0002, 0);
        after_done("b2b_op2", 32'hFFFF_FFF5);

        // Randomized ops against the arithmetic reference.
        for (int n = 0; n < 24; n++) begin
            mul = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 200)) - 32'd100;
                         rb = 32'($urandom_range(0, 20)) - 32'd10; end
                2: begin ra = $urandom; rb = 32'($urandom_range(0, 2000)) - 32'd1000; end
                default: begin ra = 32'($urandom_range(0, 70000)) - 32'd35000;
                               rb = 32'($urandom_range(0, 140000)) - 32'd70000; end
            endcase
            model(mul, ra, rb, mr, me);
            run_op("rand", mul, ra, rb, mr, me);
        end

        // Back-to-back random pair through the DONE restart path.
        ra = $urandom;
        rb = 32'($urandom_range(1, 500));
        model(1'b0, ra, rb, r1, me);
        drive_start(1'b0, ra, rb, 32'hCCCC_0001);
        expect_completion("rand_b2b1", r1, me, 32'hCCCC_0001, 0);
        ra = 32'($urandom_range(0, 60000)) - 32'd30000;
        rb = 32'($urandom_range(0, 60000)) - 32'd30000;
        model(1'b1, ra, rb, mr, me);
        drive_start(1'b1, ra, rb, 32'hCCCC_0002);
        check("rand_b2b_hold", {32'd0, o_result}, {32'd0, r1});
        expect_completion("rand_b2b2", mr, me, 32'hCCCC_0002, 0);
        after_done("rand_b2b2", mr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
